// File: rtl/csr_counter_timer_if.sv
`default_nettype none
// ============================================================================
// Module  : csr_counter_timer_if
// Brief   : CSR read/write bus between the CSR unit (master) and the
//           counter/timer block (slave).
// Revision: 1.0 - initial release
// ============================================================================
interface csr_counter_timer_if #(
    parameter int XLEN = 32
);
    logic [11:0]     csr_address_r;
    logic [XLEN-1:0] csr_data;
    logic            csr_hit;
    logic            csr_rd_illegal;
    logic            csr_we;
    logic [11:0]     csr_address_wb;
    logic [XLEN-1:0] csr_wb;
    logic            csr_wr_illegal;
    logic [1:0]      current_mode;

    modport master (
        output csr_address_r, csr_we, csr_address_wb, csr_wb, current_mode,
        input  csr_data, csr_hit, csr_rd_illegal, csr_wr_illegal
    );

    modport slave (
        input  csr_address_r, csr_we, csr_address_wb, csr_wb, current_mode,
        output csr_data, csr_hit, csr_rd_illegal, csr_wr_illegal
    );
endinterface
`default_nettype wire

// File: rtl/csr_counter_timer.sv
`default_nettype none
// ============================================================================
// Module  : csr_counter_timer
// Brief   : 64-bit mtime/mcycle/minstret/mhpmcounter block with timer-compare
//           interrupts and counter access control. Optional overflow
//           interrupt enabled by defining HPM_OVF_IRQ_EN.
// Revision: 1.0 - initial release
// ============================================================================
module csr_counter_timer #(
    parameter int XLEN     = 32,
    parameter int NUM_HPM  = 4,
    parameter int NUM_TCMP = 3,
    parameter int TIME_DIV = 1
) (
    input  logic                clk,
    input  logic                rst,
    csr_counter_timer_if.slave  bus,
    input  logic                instret_inc,
    input  logic [NUM_HPM-1:0]  hpm_event,
    output logic [NUM_TCMP-1:0] timer_irq,
    output logic                hpm_ovf_irq
);

    localparam int c_NCTR = 3 + NUM_HPM;
    localparam int c_PW   = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
    localparam logic [XLEN-1:0] c_CTR_MASK = (c_NCTR >= XLEN) ? {XLEN{1'b1}}
                                           : XLEN'((64'd1 << c_NCTR) - 64'd1);
    localparam logic [XLEN-1:0] c_INH_MASK = c_CTR_MASK & ~XLEN'(2);
`ifdef HPM_OVF_IRQ_EN
    localparam logic [XLEN-1:0] c_HPM_MASK = c_CTR_MASK & ~XLEN'(7);
`endif

    function automatic logic f_is_ctr_m(input logic [11:0] a);
        return (a[11:5] == 7'h58) || (a[11:5] == 7'h5C);
    endfunction

    function automatic logic f_is_ctr_u(input logic [11:0] a);
        return (a[11:5] == 7'h60) || (a[11:5] == 7'h64);
    endfunction

    function automatic logic f_is_tcmp(input logic [11:0] a);
        return (a[11:4] == 8'h7C) && ({1'b0, a[3:0]} < 5'(2 * NUM_TCMP));
    endfunction

    function automatic logic f_is_ovf(input logic [11:0] a);
`ifdef HPM_OVF_IRQ_EN
        return (a == 12'h7E0) || (a == 12'h7E1);
`else
        return (a == 12'hFFF) && (a != 12'hFFF);
`endif
    endfunction

    function automatic logic f_is_mach(input logic [11:0] a);
        return f_is_ctr_m(a) || (a == 12'h320) || (a == 12'h306) || f_is_tcmp(a) || f_is_ovf(a);
    endfunction

    function automatic logic f_hit(input logic [11:0] a);
        return f_is_mach(a) || f_is_ctr_u(a) || (a == 12'h106);
    endfunction

    logic [11:0]     w_ra;
    logic [11:0]     w_wa;
    logic [4:0]      w_ridx;
    logic            w_mode_m;
    logic            w_mode_s;
    logic            w_wr_illegal;
    logic            w_wr_ok;
    logic            w_rd_illegal;
    logic [XLEN-1:0] w_rdata;
    logic            w_tick;
    logic [63:0]     w_ctr  [0:31];
    logic [63:0]     w_tcmp [0:7];
    logic [XLEN-1:0] r_inhibit;
    logic [XLEN-1:0] r_mcounteren;
    logic [XLEN-1:0] r_scounteren;
    logic [c_PW-1:0] r_presc;
`ifdef HPM_OVF_IRQ_EN
    logic [31:0]     w_wrap;
    logic [XLEN-1:0] r_ovf;
    logic [XLEN-1:0] r_ovf_en;
    logic            r_ovf_irq;
`endif

    assign w_ra     = bus.csr_address_r;
    assign w_wa     = bus.csr_address_wb;
    assign w_ridx   = w_ra[4:0];
    assign w_mode_m = (bus.current_mode == 2'd3);
    assign w_mode_s = (bus.current_mode == 2'd1);

    // Shadow window is read-only from any mode; machine CSRs need M mode.
    assign w_wr_illegal = bus.csr_we && ((w_wa[11:8] == 4'hC) ||
                          (!w_mode_m && (f_is_mach(w_wa) || ((w_wa == 12'h106) && !w_mode_s))));
    assign w_wr_ok      = bus.csr_we && f_hit(w_wa) && !w_wr_illegal;

    assign bus.csr_wr_illegal = w_wr_illegal;
    assign bus.csr_hit        = f_hit(w_ra);
    assign bus.csr_rd_illegal = w_rd_illegal;
    assign bus.csr_data       = w_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inhibit    <= '0;
            r_mcounteren <= '0;
            r_scounteren <= '0;
        end else if (w_wr_ok) begin
            if (w_wa == 12'h320) r_inhibit    <= bus.csr_wb & c_INH_MASK;
            if (w_wa == 12'h306) r_mcounteren <= bus.csr_wb & c_CTR_MASK;
            if (w_wa == 12'h106) r_scounteren <= bus.csr_wb & c_CTR_MASK;
        end
    end

    assign w_tick = (r_presc == c_PW'(TIME_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || w_tick) r_presc <= '0;
        else               r_presc <= r_presc + 1'b1;
    end

    // Slot i of w_ctr follows the CSR counter index; slot 1 is mtime.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_ctr
            if (gi == 1) begin : g_time
                logic [63:0] r_mtime;
                always_ff @(posedge clk) begin
                    if (rst)         r_mtime <= '0;
                    else if (w_tick) r_mtime <= r_mtime + 64'd1;
                end
                assign w_ctr[gi] = r_mtime;
`ifdef HPM_OVF_IRQ_EN
                assign w_wrap[gi] = 1'b0;
`endif
            end else if (gi < c_NCTR) begin : g_impl
                logic        w_inc;
                logic        w_wlo;
                logic        w_whi;
                logic [63:0] r_val;
                if (gi == 0) begin : g_cycle
                    assign w_inc = ~r_inhibit[0];
                end else if (gi == 2) begin : g_instret
                    assign w_inc = instret_inc & ~r_inhibit[2];
                end else begin : g_hpm
                    assign w_inc = hpm_event[gi-3] & ~r_inhibit[gi];
                end
                assign w_wlo = w_wr_ok && (w_wa == 12'hB00 + 12'(gi));
                assign w_whi = w_wr_ok && (w_wa == 12'hB80 + 12'(gi));
                always_ff @(posedge clk) begin
                    if (rst)        r_val <= '0;
                    else if (w_wlo) r_val <= {r_val[63:XLEN], bus.csr_wb};
                    else if (w_whi) r_val <= {bus.csr_wb, r_val[XLEN-1:0]};
                    else if (w_inc) r_val <= r_val + 64'd1;
                end
                assign w_ctr[gi] = r_val;
`ifdef HPM_OVF_IRQ_EN
                assign w_wrap[gi] = w_inc & ~w_wlo & ~w_whi & (&r_val);
`endif
            end else begin : g_none
                assign w_ctr[gi] = '0;
`ifdef HPM_OVF_IRQ_EN
                assign w_wrap[gi] = 1'b0;
`endif
            end
        end
    endgenerate

    genvar gk;
    generate
        for (gk = 0; gk < 8; gk++) begin : g_tcmp
            if (gk < NUM_TCMP) begin : g_chan
                logic [63:0] r_cmp;
                logic        r_irq;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_cmp <= '1;
                        r_irq <= 1'b0;
                    end else begin
                        if (w_wr_ok && (w_wa == 12'h7C0 + 12'(2 * gk)))
                            r_cmp <= {r_cmp[63:XLEN], bus.csr_wb};
                        else if (w_wr_ok && (w_wa == 12'h7C1 + 12'(2 * gk)))
                            r_cmp <= {bus.csr_wb, r_cmp[XLEN-1:0]};
                        r_irq <= (w_ctr[1] >= r_cmp);
                    end
                end
                assign w_tcmp[gk]    = r_cmp;
                assign timer_irq[gk] = r_irq;
            end else begin : g_unused
                assign w_tcmp[gk] = '0;
            end
        end
    endgenerate

`ifdef HPM_OVF_IRQ_EN
    // A wrap in the same cycle as a write-1-to-clear keeps the bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf     <= '0;
            r_ovf_en  <= '0;
            r_ovf_irq <= 1'b0;
        end else begin
            r_ovf <= (r_ovf & ~((w_wr_ok && (w_wa == 12'h7E0)) ? bus.csr_wb : '0))
                   | (w_wrap & c_HPM_MASK);
            if (w_wr_ok && (w_wa == 12'h7E1)) r_ovf_en <= bus.csr_wb & c_HPM_MASK;
            r_ovf_irq <= |(r_ovf & r_ovf_en);
        end
    end
    assign hpm_ovf_irq = r_ovf_irq;
`else
    assign hpm_ovf_irq = 1'b0;
`endif

    always_comb begin
        w_rdata      = '0;
        w_rd_illegal = 1'b0;
        if (f_is_ctr_m(w_ra) || f_is_ctr_u(w_ra)) begin
            if (!(f_is_ctr_m(w_ra) && (w_ridx == 5'd1)))
                w_rdata = w_ra[7] ? w_ctr[w_ridx][63:XLEN] : w_ctr[w_ridx][XLEN-1:0];
        end else if (w_ra == 12'h320) begin
            w_rdata = r_inhibit;
        end else if (w_ra == 12'h306) begin
            w_rdata = r_mcounteren;
        end else if (w_ra == 12'h106) begin
            w_rdata = r_scounteren;
        end else if (f_is_tcmp(w_ra)) begin
            w_rdata = w_ra[0] ? w_tcmp[w_ra[3:1]][63:XLEN] : w_tcmp[w_ra[3:1]][XLEN-1:0];
        end
`ifdef HPM_OVF_IRQ_EN
        if (w_ra == 12'h7E0) w_rdata = r_ovf;
        if (w_ra == 12'h7E1) w_rdata = r_ovf_en;
`endif
        if (!w_mode_m) begin
            if (f_is_mach(w_ra))
                w_rd_illegal = 1'b1;
            else if (f_is_ctr_u(w_ra))
                w_rd_illegal = !(r_mcounteren[w_ridx] && (w_mode_s || r_scounteren[w_ridx]));
            else if (w_ra == 12'h106)
                w_rd_illegal = !w_mode_s;
        end
        if (w_rd_illegal) w_rdata = '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_counter_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_csr_counter_timer
// Brief   : Directed self-checking bench for csr_counter_timer (XLEN=32,
//           NUM_HPM=4, NUM_TCMP=3, TIME_DIV=1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_csr_counter_timer;

    logic        clk;
    logic        rst;
    logic        instret_inc;
    logic [3:0]  hpm_event;
    logic [2:0]  timer_irq;
    logic        hpm_ovf_irq;
    int          n_total;
    int          n_bad;
    int          n_edges;
    logic [31:0] r_data;
    logic        r_ill;
    logic        r_hit;

    csr_counter_timer_if #(.XLEN(32)) bus_if ();

    csr_counter_timer #(
        .XLEN     (32),
        .NUM_HPM  (4),
        .NUM_TCMP (3),
        .TIME_DIV (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .instret_inc (instret_inc),
        .hpm_event   (hpm_event),
        .timer_irq   (timer_irq),
        .hpm_ovf_irq (hpm_ovf_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            n_edges++;
        end
        #1;
    endtask

    task automatic rd(input logic [11:0] a);
        bus_if.csr_address_r = a;
        #1;
        r_data = bus_if.csr_data;
        r_ill  = bus_if.csr_rd_illegal;
        r_hit  = bus_if.csr_hit;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus_if.csr_we         = 1'b1;
        bus_if.csr_address_wb = a;
        bus_if.csr_wb         = d;
        tick(1);
        bus_if.csr_we         = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        n_edges = 0;
        rst = 1'b1;
        instret_inc = 1'b0;
        hpm_event = '0;
        bus_if.csr_address_r  = '0;
        bus_if.csr_we         = 1'b0;
        bus_if.csr_address_wb = '0;
        bus_if.csr_wb         = '0;
        bus_if.current_mode   = 2'd3;

        // Reset state
        tick(1);
        rst = 1'b0;
        n_edges = 0;
        chk("rst_timer_irq", timer_irq, 0);
        chk("rst_ovf_irq", hpm_ovf_irq, 0);
        rd(12'hB00); chk("rst_mcycle", r_data, 0);
        rd(12'h7C0); chk("rst_tcmp0_lo", r_data, 32'hFFFF_FFFF);
        rd(12'h320); chk("rst_inhibit", r_data, 0);

        // 10 idle clocks
        tick(10);
        rd(12'hB00); chk("idle_mcycle", r_data, 10);
        chk("idle_hit", r_hit, 1);
        rd(12'hC01); chk("idle_time", r_data, 10);
        rd(12'hB02); chk("idle_minstret", r_data, 0);
        chk("idle_timer_irq", timer_irq, 0);

        // mcycle write wins over increment, then 64-bit wrap
        wr(12'hB00, 32'hFFFF_FFFE);
        rd(12'hB00); chk("wr_lo_no_inc", r_data, 32'hFFFF_FFFE);
        rd(12'hB80); chk("wr_lo_hi_kept", r_data, 0);
        wr(12'hB80, 32'hFFFF_FFFF);
        tick(2);
        rd(12'hB00); chk("wrap_lo", r_data, 0);
        rd(12'hB80); chk("wrap_hi", r_data, 0);
        tick(1);
        rd(12'hB00); chk("after_wrap_lo", r_data, 1);
        rd(12'hB80); chk("after_wrap_hi", r_data, 0);

        // Timer compare channel 0
        wr(12'h7C0, 32'd20);
        wr(12'h7C1, 32'd0);
        rd(12'h7C0); chk("tcmp0_lo_rb", r_data, 20);
        while (n_edges < 20) tick(1);
        rd(12'hC01); chk("mtime_at_20", r_data, 20);
        chk("irq_before_rise", timer_irq, 3'b000);
        tick(1);
        chk("irq_rise", timer_irq, 3'b001);
        wr(12'h7C1, 32'd1);
        chk("irq_hold_on_write", timer_irq, 3'b001);
        tick(1);
        chk("irq_drop", timer_irq, 3'b000);
        rd(12'h7C1); chk("tcmp0_hi_rb", r_data, 1);

        // Privilege and counteren access control
        wr(12'h306, 32'd1);
        bus_if.current_mode = 2'd0;
        rd(12'hC00); chk("u_rd_denied_ill", r_ill, 1);
        chk("u_rd_denied_data", r_data, 0);
        bus_if.current_mode = 2'd3;
        wr(12'h106, 32'd1);
        bus_if.current_mode = 2'd0;
        rd(12'hC00); chk("u_rd_ok_ill", r_ill, 0);
        chk("u_rd_ok_data", r_data, n_edges - 14);
        rd(12'hC01); chk("u_rd_time_denied", r_ill, 1);
        rd(12'hB00); chk("u_rd_mach_denied", r_ill, 1);
        bus_if.csr_we = 1'b1;
        bus_if.csr_address_wb = 12'hC00;
        bus_if.csr_wb = 32'd0;
        #1;
        chk("u_wr_shadow_ill", bus_if.csr_wr_illegal, 1);
        tick(1);
        bus_if.csr_address_wb = 12'hB00;
        #1;
        chk("u_wr_mach_ill", bus_if.csr_wr_illegal, 1);
        tick(1);
        bus_if.csr_we = 1'b0;
        bus_if.current_mode = 2'd3;
        rd(12'hB00); chk("illegal_wr_no_effect", r_data, n_edges - 14);
        bus_if.current_mode = 2'd1;
        rd(12'hC00); chk("s_rd_cycle_ok", r_ill, 0);
        rd(12'hC02); chk("s_rd_instret_denied", r_ill, 1);
        rd(12'h320); chk("s_rd_mach_denied", r_ill, 1);
        bus_if.current_mode = 2'd3;

        // Inhibit and HPM events
        wr(12'h320, 32'h8);
        hpm_event = 4'b0001;
        tick(5);
        hpm_event = 4'b0000;
        rd(12'hB03); chk("hpm3_inhibited", r_data, 0);
        wr(12'h320, 32'h0);
        hpm_event = 4'b0001;
        tick(5);
        hpm_event = 4'b0000;
        rd(12'hB03); chk("hpm3_count", r_data, 5);
        rd(12'hC03); chk("hpm3_shadow", r_data, 5);
        rd(12'hB83); chk("hpm3_hi", r_data, 0);
        rd(12'hB1F); chk("unimpl_hpm_data", r_data, 0);
        chk("unimpl_hpm_ill", r_ill, 0);
        chk("unimpl_hpm_hit", r_hit, 1);

        // minstret, inhibit masking and freeze
        instret_inc = 1'b1;
        tick(3);
        instret_inc = 1'b0;
        rd(12'hB02); chk("minstret_count", r_data, 3);
        wr(12'h320, 32'hFFFF_FFFF);
        rd(12'h320); chk("inhibit_mask", r_data, 32'h7D);
        tick(3);
        rd(12'hB00); chk("mcycle_frozen", r_data, n_edges - 3 - 14);
        instret_inc = 1'b1;
        tick(2);
        instret_inc = 1'b0;
        rd(12'hB02); chk("minstret_frozen", r_data, 3);
        wr(12'h320, 32'h0);
        wr(12'h306, 32'hFFFF_FFFF);
        rd(12'h306); chk("mcounteren_mask", r_data, 32'h7F);
        rd(12'h7C4); chk("tcmp2_rst", r_data, 32'hFFFF_FFFF);
        rd(12'h7C6); chk("tcmp3_no_hit", r_hit, 0);
`ifdef HPM_OVF_IRQ_EN
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'hB83, 32'hFFFF_FFFF);
        wr(12'h7E1, 32'h8);
        hpm_event = 4'b0001;
        tick(1);
        hpm_event = 4'b0000;
        rd(12'hB03); chk("ovf_hpm3_wrapped", r_data, 0);
        rd(12'h7E0); chk("ovf_status", r_data, 32'h8);
        chk("ovf_irq_not_yet", hpm_ovf_irq, 0);
        tick(1);
        chk("ovf_irq_set", hpm_ovf_irq, 1);
        wr(12'h7E0, 32'h8);
        rd(12'h7E0); chk("ovf_cleared", r_data, 0);
        tick(1);
        chk("ovf_irq_clear", hpm_ovf_irq, 0);
`else
        rd(12'h7E0); chk("ovf_no_hit", r_hit, 0);
        chk("ovf_irq_tied", hpm_ovf_irq, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
